kernel_fifo_ctrl: RTL

KERNEL_FIFO_CTRL -- requirements
Module: kernel_fifo_ctrl

---
 rtl/kernel_fifo_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/kernel_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// kernel_fifo_ctrl
//
// Streams convolution kernel weights from a single-word weight memory into an
// external kernel FIFO, then pops one READ_PORTS-word window per input channel
// and presents it to the convolution engine over a valid/ready handshake.
//
// Ports
//   i_clock               single clock, rising edge
//   i_reset               synchronous, active-low reset
//   i_start               pulse; starts a job when idle
//   i_num_channels        channels (windows) in the job, latched on start
//   i_base_addr           first weight word address, latched on start
//   o_mem_req/o_mem_addr  one-word read request to weight memory
//   i_mem_rvalid/rdata    in-order read return, latency >= 1
//   o_fifo_wenable/wdata  FIFO write port (straight from the memory return)
//   o_fifo_renable        FIFO window read strobe (pops READ_PORTS words)
//   i_fifo_element_count  FIFO occupancy (registered inside the FIFO)
//   o_channel             channel index of the presented window
//   o_kernel_valid        window valid; FIFO read data is the payload
//   i_kernel_ready        conv engine accepts the window
//   o_busy / o_done       job active / one-cycle completion pulse
// -----------------------------------------------------------------------------
module kernel_fifo_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int READ_PORTS = 9,
    parameter int FIFO_DEPTH = 16,
    parameter int CH_WIDTH   = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [CH_WIDTH-1:0]   i_num_channels,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    output logic                  o_mem_req,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic                  i_mem_rvalid,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_fifo_wenable,
    output logic [DATA_WIDTH-1:0] o_fifo_wdata,
    output logic                  o_fifo_renable,
    input  logic [CNT_WIDTH-1:0]  i_fifo_element_count,
    output logic [CH_WIDTH-1:0]   o_channel,
    output logic                  o_kernel_valid,
    input  logic                  i_kernel_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    // num_channels * READ_PORTS fits in CH_WIDTH+4 bits for READ_PORTS <= 16
    localparam int TOT_W = CH_WIDTH + 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } top_state_t;

    typedef enum logic [1:0] {
        RD_WAIT    = 2'd0,
        RD_LOAD    = 2'd1,
        RD_PRESENT = 2'd2
    } rd_state_t;

    top_state_t            top_state;
    rd_state_t             rd_state;
    logic [CH_WIDTH-1:0]   num_ch;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [TOT_W-1:0]      total_words;
    logic [TOT_W-1:0]      words_requested;
    logic [CNT_WIDTH-1:0]  outstanding;
    logic [CH_WIDTH-1:0]   windows_issued;
    logic [CH_WIDTH-1:0]   channel;

    logic [CNT_WIDTH:0]    credit_sum;
    logic                  mem_req;
    logic                  load_go;
    logic                  handshake;
    logic                  last_window;

    // Request credit, window-load and handshake decisions from registered state
    always_comb begin
        credit_sum  = {1'b0, i_fifo_element_count} + {1'b0, outstanding};
        mem_req     = 1'b0;
        load_go     = 1'b0;
        handshake   = 1'b0;
        last_window = 1'b0;
        if (top_state == RUN) begin
            // Count words already in flight so returns can never overfill the FIFO
            mem_req   = (words_requested < total_words) &&
                        (credit_sum < (CNT_WIDTH + 1)'(FIFO_DEPTH));
            load_go   = (rd_state == RD_WAIT) &&
                        (i_fifo_element_count >= CNT_WIDTH'(READ_PORTS)) &&
                        (windows_issued < num_ch);
            handshake = (rd_state == RD_PRESENT) && i_kernel_ready;
            last_window = handshake && (channel == (num_ch - CH_WIDTH'(1)));
        end else begin
            mem_req     = 1'b0;
        end
    end

    assign o_mem_req      = mem_req;
    assign o_mem_addr     = base_addr + ADDR_WIDTH'(words_requested);
    // Memory returns pass straight into the FIFO; stale returns outside RUN are dropped
    assign o_fifo_wenable = i_mem_rvalid && (top_state == RUN);
    assign o_fifo_wdata   = i_mem_rdata;
    assign o_fifo_renable = (rd_state == RD_LOAD);
    assign o_kernel_valid = (rd_state == RD_PRESENT);
    assign o_channel      = channel;
    assign o_busy         = (top_state != IDLE);
    assign o_done         = (top_state == DONE);

    // Top job FSM, fetch counters and window read sub-FSM
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            top_state       <= IDLE;
            rd_state        <= RD_WAIT;
            num_ch          <= '0;
            base_addr       <= '0;
            total_words     <= '0;
            words_requested <= '0;
            outstanding     <= '0;
            windows_issued  <= '0;
            channel         <= '0;
        end else begin
            case (top_state)
                IDLE: begin
                    rd_state <= RD_WAIT;
                    if (i_start) begin
                        num_ch          <= i_num_channels;
                        base_addr       <= i_base_addr;
                        total_words     <= TOT_W'(i_num_channels) * TOT_W'(READ_PORTS);
                        words_requested <= '0;
                        outstanding     <= '0;
                        windows_issued  <= '0;
                        channel         <= '0;
                        top_state       <= (i_num_channels == '0) ? DONE : RUN;
                    end else begin
                        top_state <= IDLE;
                    end
                end
                RUN: begin
                    if (mem_req) begin
                        words_requested <= words_requested + TOT_W'(1);
                    end else begin
                        words_requested <= words_requested;
                    end
                    // Issue and return in the same cycle cancel out
                    if (mem_req && !i_mem_rvalid) begin
                        outstanding <= outstanding + CNT_WIDTH'(1);
                    end else if (!mem_req && i_mem_rvalid) begin
                        outstanding <= outstanding - CNT_WIDTH'(1);
                    end else begin
                        outstanding <= outstanding;
                    end
                    case (rd_state)
                        RD_WAIT: begin
                            if (load_go) begin
                                rd_state       <= RD_LOAD;
                                windows_issued <= windows_issued + CH_WIDTH'(1);
                            end else begin
                                rd_state <= RD_WAIT;
                            end
                        end
                        // FIFO read data appears one cycle after the strobe
                        RD_LOAD: rd_state <= RD_PRESENT;
                        RD_PRESENT: begin
                            if (last_window) begin
                                rd_state  <= RD_WAIT;
                                channel   <= '0;
                                top_state <= DONE;
                            end else if (handshake) begin
                                rd_state <= RD_WAIT;
                                channel  <= channel + CH_WIDTH'(1);
                            end else begin
                                rd_state <= RD_PRESENT;
                            end
                        end
                        default: rd_state <= RD_WAIT;
                    endcase
                end
                DONE: begin
                    rd_state  <= RD_WAIT;
                    top_state <= IDLE;
                end
                default: begin
                    rd_state  <= RD_WAIT;
                    top_state <= IDLE;
                end
            endcase
        end
    end

endmodule
